// File: rtl/xbar_rr_scheduler.sv
// Round-robin scheduler for a one-output blocking crossbar: picks a requester,
// programs the crossbar select over a val/rdy control port, then grants a bounded burst.
module xbar_rr_scheduler #(
    parameter int N_INPUTS          = 2,
    parameter int CONTROL_BIT_WIDTH = 32,
    parameter int BURST_LEN         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_INPUTS-1:0]          req_val,
    input  logic                         xfer_fire,
    output logic [CONTROL_BIT_WIDTH-1:0] control,
    output logic                         control_val,
    input  logic                         control_rdy,
    output logic                         xfer_en,
    output logic [$clog2(N_INPUTS)-1:0]  grant_idx,
    output logic                         busy
);

    localparam int IDX_W = $clog2(N_INPUTS);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, CONFIG, GRANT} state_t;

    state_t                       state, state_n;
    logic [CONTROL_BIT_WIDTH-1:0] control_n, ctrl_word;
    logic                         control_val_n, xfer_en_n, found;
    logic [IDX_W-1:0]             grant_idx_n, last, last_n, winner, cand;
    logic [CNT_W-1:0]             count, count_n;

    assign busy = (state != IDLE);

    // Rotating priority: the first requester strictly after the last completed grant wins.
    always_comb begin
        winner = last;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_INPUTS; k++) begin
            cand = IDX_W'((int'(last) + k) % N_INPUTS);
            if (!found && req_val[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        ctrl_word = '0;
        ctrl_word[CONTROL_BIT_WIDTH-1 -: IDX_W] = winner;
    end

    always_comb begin
        state_n       = state;
        control_n     = control;
        control_val_n = control_val;
        xfer_en_n     = xfer_en;
        grant_idx_n   = grant_idx;
        count_n       = count;
        last_n        = last;
        case (state)
            IDLE: begin
                if (|req_val) begin
                    state_n       = CONFIG;
                    grant_idx_n   = winner;
                    control_n     = ctrl_word;
                    control_val_n = 1'b1;
                end
            end
            CONFIG: begin
                if (control_rdy) begin
                    state_n       = GRANT;
                    control_val_n = 1'b0;
                    xfer_en_n     = 1'b1;
                    count_n       = '0;
                    last_n        = grant_idx;
                end
            end
            GRANT: begin
                if (xfer_fire && count < CNT_W'(BURST_LEN)) begin
                    count_n = count + 1'b1;
                end
                // A fire in the releasing cycle is still counted before dropping to IDLE.
                if ((xfer_fire && count_n == CNT_W'(BURST_LEN)) || !req_val[grant_idx]) begin
                    state_n   = IDLE;
                    xfer_en_n = 1'b0;
                end
            end
            default: begin
                state_n       = IDLE;
                control_val_n = 1'b0;
                xfer_en_n     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            control     <= '0;
            control_val <= 1'b0;
            xfer_en     <= 1'b0;
            grant_idx   <= '0;
            count       <= '0;
            last        <= IDX_W'(N_INPUTS - 1);
        end else begin
            state       <= state_n;
            control     <= control_n;
            control_val <= control_val_n;
            xfer_en     <= xfer_en_n;
            grant_idx   <= grant_idx_n;
            count       <= count_n;
            last        <= last_n;
        end
    end

endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// Directed testbench for xbar_rr_scheduler (N_INPUTS=2, 32-bit control, BURST_LEN=4).
module tb_xbar_rr_scheduler;

    localparam int N  = 2;
    localparam int CW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_val;
    logic          xfer_fire;
    logic [CW-1:0] control;
    logic          control_val;
    logic          control_rdy;
    logic          xfer_en;
    logic [0:0]    grant_idx;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    xbar_rr_scheduler #(.N_INPUTS(N), .CONTROL_BIT_WIDTH(CW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_val    (req_val),
        .xfer_fire  (xfer_fire),
        .control    (control),
        .control_val(control_val),
        .control_rdy(control_rdy),
        .xfer_en    (xfer_en),
        .grant_idx  (grant_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic rdy, input logic fire);
        req_val     = r;
        control_rdy = rdy;
        xfer_fire   = fire;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_cv"},    32'(control_val), 32'd0);
        checkOutput({tag, "_xen"},   32'(xfer_en),     32'd0);
        checkOutput({tag, "_busy"},  32'(busy),        32'd0);
        checkOutput({tag, "_grant"}, 32'(grant_idx),   32'd0);
        checkOutput({tag, "_ctrl"},  control,          32'd0);
    endtask

    // Starts in IDLE with a request pending and control_rdy/xfer_fire held high.
    task automatic run_grant(input string tag, input int exp_idx, input logic [31:0] exp_ctrl,
                             input int exp_len);
        int n;
        step();
        checkOutput({tag, "_cfg_cv"},    32'(control_val), 32'd1);
        checkOutput({tag, "_cfg_ctrl"},  control,          exp_ctrl);
        checkOutput({tag, "_cfg_grant"}, 32'(grant_idx),   32'(exp_idx));
        checkOutput({tag, "_cfg_xen"},   32'(xfer_en),     32'd0);
        step();
        checkOutput({tag, "_gnt_xen"},   32'(xfer_en),     32'd1);
        checkOutput({tag, "_gnt_cv"},    32'(control_val), 32'd0);
        n = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!xfer_en) break;
            n++;
        end
        checkOutput({tag, "_burst_len"}, 32'(n),    32'(exp_len));
        checkOutput({tag, "_rel_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0);
        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;

        // Test 1: idle with no requests
        for (int i = 0; i < 10; i++) step();
        check_reset_values("idle10");

        // Test 2: lone requester 0, full burst, then no regrant once request is gone
        applyStimulus(2'b01, 1'b1, 1'b1);
        run_grant("t2", 0, 32'h0000_0000, BL);
        applyStimulus(2'b00, 1'b1, 1'b0);
        step();
        checkOutput("t2_idle_busy",  32'(busy),      32'd0);
        checkOutput("t2_idle_grant", 32'(grant_idx), 32'd0);

        // Test 3: both requesting after reset -> 0,1,0,1
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(2'b11, 1'b1, 1'b1);
        for (int g = 0; g < 4; g++) begin
            run_grant($sformatf("t3_g%0d", g), g % 2,
                      (g % 2 == 1) ? 32'h8000_0000 : 32'h0000_0000, BL);
        end

        // Test 4: control_rdy low in CONFIG holds the word; winner fixed despite req change
        applyStimulus(2'b00, 1'b0, 1'b0);
        step();
        applyStimulus(2'b10, 1'b0, 1'b0);
        step();
        checkOutput("t4_cv",    32'(control_val), 32'd1);
        checkOutput("t4_ctrl",  control,          32'h8000_0000);
        checkOutput("t4_grant", 32'(grant_idx),   32'd1);
        applyStimulus(2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("t4_hold%0d_cv", i),    32'(control_val), 32'd1);
            checkOutput($sformatf("t4_hold%0d_ctrl", i),  control,          32'h8000_0000);
            checkOutput($sformatf("t4_hold%0d_grant", i), 32'(grant_idx),   32'd1);
            checkOutput($sformatf("t4_hold%0d_xen", i),   32'(xfer_en),     32'd0);
        end
        applyStimulus(2'b11, 1'b1, 1'b0);
        step();
        checkOutput("t4_gnt_xen", 32'(xfer_en),     32'd1);
        checkOutput("t4_gnt_cv",  32'(control_val), 32'd0);

        // Test 5: requester 1 drops after two fires -> release, then input 0 wins
        applyStimulus(2'b11, 1'b1, 1'b1);
        step();
        checkOutput("t5_fire1_xen", 32'(xfer_en), 32'd1);
        step();
        checkOutput("t5_fire2_xen", 32'(xfer_en), 32'd1);
        applyStimulus(2'b01, 1'b1, 1'b0);
        step();
        checkOutput("t5_rel_xen",  32'(xfer_en), 32'd0);
        checkOutput("t5_rel_busy", 32'(busy),    32'd0);
        step();
        checkOutput("t5_next_grant", 32'(grant_idx),   32'd0);
        checkOutput("t5_next_cv",    32'(control_val), 32'd1);
        checkOutput("t5_next_ctrl",  control,          32'h0000_0000);
        step();
        checkOutput("t5_next_xen", 32'(xfer_en), 32'd1);

        // Test 6: reset mid-burst aborts; pointer restarts so input 0 wins again
        applyStimulus(2'b01, 1'b1, 1'b1);
        step();
        checkOutput("t6_fire_xen", 32'(xfer_en), 32'd1);
        reset = 1'b1;
        applyStimulus(2'b11, 1'b1, 1'b0);
        step();
        check_reset_values("t6_rst");
        reset = 1'b0;
        step();
        checkOutput("t6_after_cv",    32'(control_val), 32'd1);
        checkOutput("t6_after_grant", 32'(grant_idx),   32'd0);
        checkOutput("t6_after_ctrl",  control,          32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
